// File: rtl/mul16_seq.sv
// Sequential 16x16 unsigned shift-and-add multiplier with a start/done handshake.
// Optional build macro MUL_EARLY_EXIT_EN leaves RUN as soon as the remaining multiplier bits are zero.
module mul16_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] product
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] mcand_reg, mcand_next;
    logic [15:0] mplier_reg, mplier_next;
    logic [31:0] acc_reg, acc_next;
    logic [3:0]  cnt_reg, cnt_next;
    logic [31:0] product_reg, product_next;

    // One 32-bit add built as two chained 16-bit halves: low half first, carry into high half.
    logic        carry_lo;
    logic [31:0] sum;
    assign {carry_lo, sum[15:0]} = {1'b0, acc_reg[15:0]} + {1'b0, mcand_reg[15:0]};
    assign sum[31:16] = acc_reg[31:16] + mcand_reg[31:16] + {15'h0, carry_lo};

    logic early_exit;
`ifdef MUL_EARLY_EXIT_EN
    // The multiplier after this step's shift has no set bits left.
    assign early_exit = (mplier_reg[15:1] == 15'h0);
`else
    assign early_exit = 1'b0;
`endif

    always_comb begin
        state_next   = state_reg;
        mcand_next   = mcand_reg;
        mplier_next  = mplier_reg;
        acc_next     = acc_reg;
        cnt_next     = cnt_reg;
        product_next = product_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    mcand_next  = {16'h0, a};
                    mplier_next = b;
                    acc_next    = 32'h0;
                    cnt_next    = 4'd0;
                    state_next  = RUN;
                end
            end
            RUN: begin
                acc_next    = mplier_reg[0] ? sum : acc_reg;
                mcand_next  = mcand_reg << 1;
                mplier_next = mplier_reg >> 1;
                cnt_next    = cnt_reg + 4'd1;
                if ((cnt_reg == 4'd15) || early_exit) begin
                    // Product includes this final step's addition.
                    product_next = acc_next;
                    state_next   = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            mcand_reg   <= 32'h0;
            mplier_reg  <= 16'h0;
            acc_reg     <= 32'h0;
            cnt_reg     <= 4'd0;
            product_reg <= 32'h0;
        end else begin
            state_reg   <= state_next;
            mcand_reg   <= mcand_next;
            mplier_reg  <= mplier_next;
            acc_reg     <= acc_next;
            cnt_reg     <= cnt_next;
            product_reg <= product_next;
        end
    end

    assign busy    = (state_reg != IDLE);
    assign done    = (state_reg == DONE);
    assign product = product_reg;

endmodule

// File: tb/tb_mul16_seq.sv
// Self-checking bench for mul16_seq: vector table, expected-product queue, and
// hand-written sequences for reset, ignored starts, back-to-back and abort cases.
module tb_mul16_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [31:0] product;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];

    mul16_seq dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] av;
        logic [15:0] bv;
        logic [31:0] prod;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    // Cycles from accepting edge to the done cycle, inclusive.
    function automatic int exp_latency(input logic [15:0] bv);
        int runs;
        runs = 16;
`ifdef MUL_EARLY_EXIT_EN
        runs = 1;
        for (int i = 0; i < 16; i++) begin
            if (bv[i]) runs = i + 1;
        end
`endif
        return runs + 1;
    endfunction

    task automatic run_op(input logic [15:0] av, input logic [15:0] bv, input logic [31:0] pv, input string tag);
        int k;
        logic [31:0] req;
        @(negedge clk);
        a = av; b = bv; start = 1'b1;
        exp_q.push_back(pv);
        @(posedge clk);
        #1;
        start = 1'b0;
        a = 16'($urandom);
        b = 16'($urandom);
        k = 0;
        forever begin
            @(negedge clk);
            if (done) break;
            if (k > 40) break;
            check({tag, ".busy"}, {31'h0, busy}, 32'h1);
            @(posedge clk);
            k++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s.timeout: got no done after %0d cycles required %0d", tag, k, exp_latency(bv));
            exp_q.delete();
            return;
        end
        req = exp_q.pop_front();
        check({tag, ".latency"}, k + 1, exp_latency(bv));
        check({tag, ".product"}, product, req);
        $display("op %s: a=%h b=%h product=%h latency=%0d", tag, av, bv, product, k + 1);
        @(posedge clk);
        @(negedge clk);
        check({tag, ".done_low"}, {31'h0, done}, 32'h0);
        check({tag, ".idle"}, {31'h0, busy}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000 required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses, first_done, second_done, off;
        logic [31:0] req;

        vecs[0]  = '{16'h0003, 16'h0005, 32'h0000000F};
        vecs[1]  = '{16'hFFFF, 16'hFFFF, 32'hFFFE0001};
        vecs[2]  = '{16'h1234, 16'h0000, 32'h00000000};
        vecs[3]  = '{16'h0003, 16'h0100, 32'h00000300};
        vecs[4]  = '{16'h0001, 16'h0001, 32'h00000001};
        vecs[5]  = '{16'hFFFF, 16'h0001, 32'h0000FFFF};
        vecs[6]  = '{16'h0001, 16'h8000, 32'h00008000};
        vecs[7]  = '{16'h8000, 16'h8000, 32'h40000000};
        vecs[8]  = '{16'h0064, 16'h00C8, 32'h00004E20};
        vecs[9]  = '{16'h1234, 16'h5678, 32'h06260060};
        vecs[10] = '{16'h0000, 16'hFFFF, 32'h00000000};
        vecs[11] = '{16'hFFFF, 16'h00FF, 32'h00FEFF01};

        // Reset with start asserted: block must stay idle and cleared.
        rst = 1'b1; start = 1'b1; a = 16'h1111; b = 16'h2222;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset.busy", {31'h0, busy}, 32'h0);
        check("reset.done", {31'h0, done}, 32'h0);
        check("reset.product", product, 32'h0);
        start = 1'b0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("post_reset.busy", {31'h0, busy}, 32'h0);
        check("post_reset.done", {31'h0, done}, 32'h0);

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].av, vecs[i].bv, vecs[i].prod, $sformatf("vec%0d", i));
        end

        // A second start during RUN is ignored: one done, first product only.
`ifdef MUL_EARLY_EXIT_EN
        off = 2;
`else
        off = 5;
`endif
        @(negedge clk);
        a = 16'd2; b = 16'd7; start = 1'b1;
        exp_q.push_back(32'h0000000E);
        @(posedge clk);
        #1;
        start = 1'b0;
        pulses = 0;
        first_done = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i == off) begin
                start = 1'b1; a = 16'd9; b = 16'd9;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                pulses++;
                if (pulses == 1) first_done = i;
                req = (exp_q.size() > 0) ? exp_q.pop_front() : 32'h0;
                check("ignore.product", product, req);
            end
        end
        start = 1'b0;
        check("ignore.pulses", pulses, 32'd1);
        check("ignore.latency", first_done, exp_latency(16'd7));
        $display("op ignore: a=0002 b=0007 product=%h pulses=%0d", product, pulses);
        exp_q.delete();

        // Start held high: DONE-cycle start is not accepted, next cycle is.
        @(negedge clk);
        a = 16'd3; b = 16'd5; start = 1'b1;
        first_done = -1;
        second_done = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done) begin
                check("b2b.product", product, 32'h0000000F);
                if (first_done < 0) first_done = i;
                else if (second_done < 0) second_done = i;
            end
        end
        start = 1'b0;
        check("b2b.spacing", second_done - first_done, exp_latency(16'd5) + 1);
        $display("op b2b: a=0003 b=0005 done_spacing=%0d", second_done - first_done);
        pulses = 0;
        while (busy && pulses < 40) begin
            @(negedge clk);
            pulses++;
        end
        check("b2b.drain_idle", {31'h0, busy}, 32'h0);

        // Asynchronous reset mid-operation clears at once, then a fresh op works.
        @(negedge clk);
        a = 16'd100; b = 16'd200; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("abort.busy", {31'h0, busy}, 32'h0);
        check("abort.done", {31'h0, done}, 32'h0);
        check("abort.product", product, 32'h0);
        $display("op abort: a=0064 b=00C8 busy=%0d product=%h", busy, product);
        @(negedge clk);
        rst = 1'b0;
        run_op(16'd100, 16'd200, 32'h00004E20, "after_abort");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
